// File: rtl/game_pkg.sv
// Shared types and constants for the game field renderer: field geometry,
// pixel/colour widths, colour constants, fetch FSM states and buffer layout.
package game_pkg;

  localparam int FIELD_W   = 40;
  localparam int FIELD_H   = 30;
  localparam int CELL_LOG2 = 4;
  localparam int X_WIDTH   = 10;
  localparam int Y_WIDTH   = 10;
  localparam int RGB_WIDTH = 3;
  localparam int ROW_AW    = $clog2(FIELD_H);
  localparam int COL_AW    = $clog2(FIELD_W);

  localparam logic [RGB_WIDTH-1:0] EN_RGB  = 3'b111;
  localparam logic [RGB_WIDTH-1:0] DIS_RGB = 3'b000;
  localparam logic [RGB_WIDTH-1:0] NET_RGB = 3'b001;
  localparam logic [RGB_WIDTH-1:0] BG_RGB  = 3'b000;
  localparam logic [RGB_WIDTH-1:0] CUR_RGB = 3'b100;

  typedef enum logic {IDLE, REQ} fetch_state_e;

  typedef struct packed {
    logic              valid;
    logic [ROW_AW-1:0] tag;
    logic [FIELD_W-1:0] bits;
  } row_buf_t;

  // Stage-1 pixel decisions handed to the colour mux.
  typedef struct packed {
    logic valid;
    logic outside;
    logic grid;
    logic cursor;
    logic cell_on;
  } pix_s1_t;

  function automatic logic holds_row(row_buf_t b, logic [ROW_AW-1:0] r);
    return b.valid && (b.tag == r);
  endfunction

endpackage

// File: rtl/game_row_fetch.sv
// Row fetch engine: IDLE/REQ FSM over the req/valid read port, a single
// newest-wins pending slot, and the back/front row buffers with swap in blanking.
module game_row_fetch
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_start,
  input  logic [Y_WIDTH-1:0] next_line_y,
  input  logic               pixel_valid,
  output logic               row_rd_req,
  output logic [ROW_AW-1:0]  row_rd_addr,
  input  logic               row_rd_valid,
  input  logic [FIELD_W-1:0] row_rd_data,
  output row_buf_t           front
);

  fetch_state_e      state_q, state_d;
  logic [ROW_AW-1:0] addr_q, addr_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ROW_AW-1:0] pend_row_q, pend_row_d;
  row_buf_t          back_q, back_d;
  row_buf_t          front_q, front_d;

  logic [Y_WIDTH-1:0] row_full;
  logic               row_in_field;
  logic [ROW_AW-1:0]  row_idx;
  logic               cand_valid;
  logic [ROW_AW-1:0]  cand_row;

  assign row_full     = next_line_y >> CELL_LOG2;
  assign row_in_field = row_full < Y_WIDTH'(FIELD_H);
  assign row_idx      = row_full[ROW_AW-1:0];

  // A line_start arriving together with row data supersedes the pending slot.
  assign cand_valid = line_start ? row_in_field : pend_valid_q;
  assign cand_row   = line_start ? row_idx      : pend_row_q;

  // Next-state logic: request sequencing, buffer fill and blanking-time swap.
  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    addr_d       = addr_q;
    pend_valid_d = pend_valid_q;
    pend_row_d   = pend_row_q;
    back_d       = back_q;
    front_d      = front_q;

    case (state_q)
      IDLE: begin
        if (line_start && row_in_field &&
            !holds_row(front_q, row_idx) && !holds_row(back_q, row_idx)) begin
          state_d = REQ;
          addr_d  = row_idx;
        end
      end
      REQ: begin
        if (row_rd_valid) begin
          back_d.valid = 1'b1;
          back_d.tag   = addr_q;
          back_d.bits  = row_rd_data;
          pend_valid_d = 1'b0;
          if (cand_valid && (cand_row != addr_q) && !holds_row(front_q, cand_row)) begin
            addr_d = cand_row;
          end else begin
            state_d = IDLE;
          end
        end else if (line_start) begin
          pend_valid_d = row_in_field;
          pend_row_d   = row_idx;
        end
      end
      default: state_d = IDLE;
    endcase

    // Swap only in blanking so a visible line never changes source row.
    if (back_q.valid && !holds_row(front_q, back_q.tag) && !pixel_valid) begin
      front_d = back_q;
    end
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q      <= IDLE;
      addr_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_row_q   <= '0;
      // NOTE: only the valid flags matter after reset; the row bits are cleared as well
      // so no X can reach the colour path before the first fetch lands.
      back_q       <= '0;
      front_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pend_valid_q <= pend_valid_d;
      pend_row_q   <= pend_row_d;
      back_q       <= back_d;
      front_q      <= front_d;
    end
  end

  assign row_rd_req  = (state_q == REQ);
  assign row_rd_addr = addr_q;
  assign front       = front_q;

endmodule

// File: rtl/game_field_renderer.sv
// Two-stage pixel pipeline mapping pixels to field cells: background, grid,
// optional blinking cursor, live/dead cell colour, plus sticky underrun flag.
// Optional cursor: define GAME_RENDERER_CURSOR_EN.
module game_field_renderer
  import game_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [X_WIDTH-1:0]   pixel_x,
  input  logic [Y_WIDTH-1:0]   pixel_y,
  input  logic                 pixel_valid,
  input  logic                 line_start,
  input  logic [Y_WIDTH-1:0]   next_line_y,
  input  logic                 frame_start,
  input  logic                 enable_net,
  output logic                 row_rd_req,
  output logic [ROW_AW-1:0]    row_rd_addr,
  input  logic                 row_rd_valid,
  input  logic [FIELD_W-1:0]   row_rd_data,
  input  logic [COL_AW-1:0]    cursor_x,
  input  logic [ROW_AW-1:0]    cursor_y,
  output logic [RGB_WIDTH-1:0] rgb,
  output logic                 rgb_valid,
  output logic                 underrun
);

  row_buf_t front;

  game_row_fetch u_fetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_start   (line_start),
    .next_line_y  (next_line_y),
    .pixel_valid  (pixel_valid),
    .row_rd_req   (row_rd_req),
    .row_rd_addr  (row_rd_addr),
    .row_rd_valid (row_rd_valid),
    .row_rd_data  (row_rd_data),
    .front        (front)
  );

  logic [X_WIDTH-1:0]   cell_x;
  logic [Y_WIDTH-1:0]   cell_y;
  logic [CELL_LOG2-1:0] x_off, y_off;
  logic                 y_in_field, tag_match, cursor_hit;

  assign cell_x     = pixel_x >> CELL_LOG2;
  assign cell_y     = pixel_y >> CELL_LOG2;
  assign x_off      = pixel_x[CELL_LOG2-1:0];
  assign y_off      = pixel_y[CELL_LOG2-1:0];
  assign y_in_field = cell_y < Y_WIDTH'(FIELD_H);
  assign tag_match  = y_in_field && holds_row(front, cell_y[ROW_AW-1:0]);

`ifdef GAME_RENDERER_CURSOR_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Blink counter: one phase toggle every BLINK_FRAMES frame_start pulses.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_start) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blink state registers; cursor starts hidden.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign cursor_hit = phase_q &&
                      (cell_x == X_WIDTH'(cursor_x)) && (cell_y == Y_WIDTH'(cursor_y)) &&
                      (x_off == '0 || x_off == '1 || y_off == '0 || y_off == '1);
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_cursor;
  assign unused_cursor = ^{cursor_x, cursor_y};
  assign cursor_hit    = 1'b0;
`endif

  pix_s1_t              s1_q, s1_d;
  logic [RGB_WIDTH-1:0] rgb_q, rgb_d;
  logic                 rgb_valid_q;
  logic                 underrun_q, underrun_d;

  // Stage 1: cell decode, grid test, front-buffer bit select, underrun detect.
  always_comb begin
    s1_d.valid   = pixel_valid;
    s1_d.outside = (cell_x >= X_WIDTH'(FIELD_W)) || !y_in_field;
    s1_d.grid    = enable_net && (x_off == '0 || y_off == '0);
    s1_d.cursor  = cursor_hit;
    s1_d.cell_on = tag_match && front.bits[cell_x[COL_AW-1:0]];
    // A new underrun wins over a simultaneous frame_start clear.
    underrun_d   = (pixel_valid && y_in_field && !tag_match) || (underrun_q && !frame_start);
  end

  // Stage 2: colour priority mux; blank when the delayed pixel is inactive.
  always_comb begin
    rgb_d = '0;
    if (s1_q.valid) begin
      if (s1_q.outside)      rgb_d = BG_RGB;
      else if (s1_q.cursor)  rgb_d = CUR_RGB;
      else if (s1_q.grid)    rgb_d = NET_RGB;
      else if (s1_q.cell_on) rgb_d = EN_RGB;
      else                   rgb_d = DIS_RGB;
    end
  end

  // Pipeline and sticky-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= s1_q.valid;
      underrun_q  <= underrun_d;
    end
  end

  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_game_field_renderer.sv
// Self-checking bench for game_field_renderer: directed scenarios plus random
// frames checked against a cell-level reference model and a memory responder.
module tb_game_field_renderer;
  import game_pkg::*;

  localparam int BLINK = 2;
  localparam int BLANK = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [X_WIDTH-1:0]   pixel_x = '0;
  logic [Y_WIDTH-1:0]   pixel_y = '0;
  logic                 pixel_valid = 1'b0;
  logic                 line_start = 1'b0;
  logic [Y_WIDTH-1:0]   next_line_y = '0;
  logic                 frame_start = 1'b0;
  logic                 enable_net = 1'b0;
  logic                 row_rd_req;
  logic [ROW_AW-1:0]    row_rd_addr;
  logic                 row_rd_valid;
  logic [FIELD_W-1:0]   row_rd_data;
  logic [COL_AW-1:0]    cursor_x = '0;
  logic [ROW_AW-1:0]    cursor_y = '0;
  logic [RGB_WIDTH-1:0] rgb;
  logic                 rgb_valid;
  logic                 underrun;

  always #5 clk = ~clk;

  game_field_renderer #(.BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .line_start(line_start), .next_line_y(next_line_y),
    .frame_start(frame_start), .enable_net(enable_net), .row_rd_req(row_rd_req),
    .row_rd_addr(row_rd_addr), .row_rd_valid(row_rd_valid), .row_rd_data(row_rd_data),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .rgb(rgb), .rgb_valid(rgb_valid),
    .underrun(underrun)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Field memory contents and memory responder controls.
  logic [FIELD_W-1:0] field [FIELD_H];
  bit   mem_en = 1'b0;
  int   mem_lat = 0;
  int   req_log[$];

  // Reference model state.
  int         model_front = -1;
  bit         model_underrun = 1'b0;
  int         frames = 0;
  logic [3:0] exp_q[$];

  // Memory: answers an active request after mem_lat cycles with a 1-cycle valid.
  initial begin
    int lat;
    lat = 0;
    row_rd_valid = 1'b0;
    row_rd_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (row_rd_valid) begin
        row_rd_valid = 1'b0;
        lat = 0;
      end else if (row_rd_req && mem_en && rst_n) begin
        if (lat >= mem_lat) begin
          row_rd_valid = 1'b1;
          row_rd_data  = field[row_rd_addr];
          req_log.push_back(int'(row_rd_addr));
          lat = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  function automatic bit cursor_shown();
`ifdef GAME_RENDERER_CURSOR_EN
    return ((frames / BLINK) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected {rgb_valid, rgb} for one pixel, straight from the colour rules.
  function automatic logic [3:0] model_pix(int x, int y, bit v);
    int cx, cy, ox, oy;
    cx = x / 16; cy = y / 16; ox = x % 16; oy = y % 16;
    if (!v) return 4'h0;
    if (cx >= FIELD_W || cy >= FIELD_H) return {1'b1, BG_RGB};
    if (cursor_shown() && cx == int'(cursor_x) && cy == int'(cursor_y) &&
        (ox == 0 || ox == 15 || oy == 0 || oy == 15)) return {1'b1, CUR_RGB};
    if (enable_net && (ox == 0 || oy == 0)) return {1'b1, NET_RGB};
    if (model_front == cy && field[cy][cx]) return {1'b1, EN_RGB};
    return {1'b1, DIS_RGB};
  endfunction

  // One clock: predict from current inputs, advance, compare the pixel from 2 cycles ago.
  task automatic cycle();
    int r;
    exp_q.push_back(model_pix(int'(pixel_x), int'(pixel_y), pixel_valid));
    if (frame_start) begin
      model_underrun = 1'b0;
      frames++;
    end
    if (pixel_valid && int'(pixel_y) / 16 < FIELD_H && model_front != int'(pixel_y) / 16)
      model_underrun = 1'b1;
    if (line_start) begin
      r = int'(next_line_y) / 16;
      if (r < FIELD_H && mem_en) model_front = r;
    end
    @(posedge clk); #1;
    if (exp_q.size() >= 2) check("pix", {rgb_valid, rgb}, exp_q.pop_front());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pixel_valid = 1'b0; line_start = 1'b0; frame_start = 1'b0; mem_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    req_log.delete();
    model_front = -1; model_underrun = 1'b0; frames = 0;
    rst_n = 1'b1;
  endtask

  // Blanking with line_start for line y, then npix random pixels on that line.
  task automatic do_line(int y, int npix);
    int n, x;
    mem_lat = $urandom_range(0, 3);
    repeat (2) cycle();
    check("underrun", underrun, model_underrun);
    n = req_log.size();
    line_start = 1'b1; next_line_y = Y_WIDTH'(y);
    cycle();
    line_start = 1'b0;
    repeat (BLANK) cycle();
    for (int i = 0; i < npix; i++) begin
      if (i % 3 == 0) x = int'(cursor_x) * 16 + ((i % 2 == 0) ? 0 : 15);
      else x = $urandom_range(0, 700);
      pixel_x = X_WIDTH'(x); pixel_y = Y_WIDTH'(y); pixel_valid = 1'b1;
      cycle();
    end
    pixel_valid = 1'b0;
    if (y / 16 >= FIELD_H) check("oor_noreq", req_log.size(), n);
  endtask

  task automatic probe(string tag, int x, int y, logic [2:0] exp);
    pixel_x = X_WIDTH'(x); pixel_y = Y_WIDTH'(y); pixel_valid = 1'b1;
    cycle();
    pixel_valid = 1'b0;
    cycle();
    check(tag, rgb, exp);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
  endtask

  initial begin
    int y;
    logic [63:0] rnd;
    for (int i = 0; i < FIELD_H; i++) begin
      rnd = {$urandom(), $urandom()};
      field[i] = rnd[FIELD_W-1:0];
    end
    field[0] = 40'h1;
    field[1] = '1;

    // 1: reset values, first fetch, live cell
    do_reset();
    check("rst_rgb", rgb, 0);
    check("rst_rgb_valid", rgb_valid, 0);
    check("rst_req", row_rd_req, 0);
    check("rst_addr", row_rd_addr, 0);
    check("rst_underrun", underrun, 0);
    mem_en = 1'b1;
    do_line(0, 0);
    check("t1_nreq", req_log.size(), 1);
    check("t1_addr", (req_log.size() > 0) ? req_log[0] : -1, 0);
    probe("t1_en", 8, 8, EN_RGB);

    // 2: grid on/off
    do_line(5, 0);
    enable_net = 1'b1;
    probe("t2_net", 16, 5, NET_RGB);
    enable_net = 1'b0;
    probe("t2_cell", 16, 5, DIS_RGB);

    // 3: outside field and out-of-range line
    enable_net = 1'b1;
    probe("t3_bg", 640, 5, BG_RGB);
    do_line(480, 4);

    // 4: stalled fetch -> underrun, cleared by frame_start
    enable_net = 1'b0;
    mem_en = 1'b0;
    do_line(16, 0);
    probe("t4_dis", 24, 16, DIS_RGB);
    check("t4_underrun", underrun, 1);
    pulse_frame();
    cycle();
    check("t4_clear", underrun, 0);
    mem_en = 1'b1;
    do_line(17, 8);

    // 5: pending slot keeps only the newest row
    do_reset();
    line_start = 1'b1; next_line_y = 10'd0; cycle(); line_start = 1'b0;
    cycle();
    check("t5_req0", {row_rd_req, row_rd_addr}, {1'b1, 5'd0});
    line_start = 1'b1; next_line_y = 10'd16; cycle();
    next_line_y = 10'd32; cycle(); line_start = 1'b0;
    mem_en = 1'b1; mem_lat = 1;
    repeat (12) cycle();
    check("t5_nreq", req_log.size(), 2);
    check("t5_addr", (req_log.size() > 1) ? req_log[1] : -1, 2);

    // async reset mid-fetch drops the request at once
    mem_en = 1'b0;
    line_start = 1'b1; next_line_y = 10'd48; cycle(); line_start = 1'b0;
    cycle();
    check("t7_req", row_rd_req, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_drop", row_rd_req, 0);
    do_reset();

    // 5b: lines 1..15 of row 0 reuse the buffered row
    mem_en = 1'b1;
    for (int l = 0; l < 16; l++) do_line(l, 3);
    check("t5_reuse", req_log.size(), 1);

    // random frames
    for (int f = 0; f < 4; f++) begin
      enable_net = 1'($urandom_range(0, 1));
      cursor_x = COL_AW'($urandom_range(0, FIELD_W - 1));
      cursor_y = ROW_AW'($urandom_range(0, FIELD_H - 1));
      pulse_frame();
      y = 0;
      while (y < 520) begin
        do_line(y, 12);
        y += $urandom_range(1, 12);
      end
    end

    // 6: cursor blink (hidden in the default build)
    do_reset();
    enable_net = 1'b1; cursor_x = 6'd3; cursor_y = 5'd2; mem_en = 1'b1;
    pulse_frame(); pulse_frame();
    do_line(32, 0);
`ifdef GAME_RENDERER_CURSOR_EN
    probe("t6_cur", 48, 32, CUR_RGB);
`else
    probe("t6_cur", 48, 32, NET_RGB);
`endif
    pulse_frame(); pulse_frame();
    probe("t6_hidden", 48, 32, NET_RGB);
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
